// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INCREMENT         = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry buffer holding a returned instruction and its PC while decode is stalled.
module fetch_skid_buffer
  import riscv_fetch_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic        invalidate,
  input  logic [31:0] load_instruction,
  input  logic [31:0] load_pc,
  output logic        vld,
  output logic [31:0] instruction,
  output logic [31:0] pc
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld         <= 1'b0;
      instruction <= ZERO_WORD;
      pc          <= ZERO_WORD;
    end else if (invalidate) begin
      vld <= 1'b0;
    end else if (load) begin
      vld         <= 1'b1;
      instruction <= load_instruction;
      pc          <= load_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: drives I-cache requests, tracks next PC, skids one word under stall, flushes on branch.
// Optional perf counters (PERF_FETCHED, PERF_MISS_CYCLES) under FETCH_PERF_COUNTERS_EN.
module instruction_fetch_stage
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic        HIGH         = 1'b1,
  parameter logic        LOW          = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL_FETCH_STAGE,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        ICACHE_REQUEST,
  output logic [31:0] ICACHE_ADDRESS,
  input  logic        ICACHE_READY,
  input  logic [31:0] ICACHE_INSTRUCTION,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_OUT,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0] PERF_FETCHED,
  output logic [31:0] PERF_MISS_CYCLES,
`endif
  output logic        PC_VALID
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_reg, pc_nxt;
  logic [31:0]  stale_addr_reg, stale_nxt;
  logic [31:0]  ins_nxt, pc_out_nxt;
  logic         vld_nxt;
  logic         skid_load, skid_inv, skid_vld, fetched;
  logic [31:0]  skid_ins, skid_pc;

  fetch_skid_buffer u_skid (
    .CLK              (CLK),
    .RST              (RST),
    .load             (skid_load),
    .invalidate       (skid_inv),
    .load_instruction (ICACHE_INSTRUCTION),
    .load_pc          (pc_reg),
    .vld              (skid_vld),
    .instruction      (skid_ins),
    .pc               (skid_pc)
  );

  // DISCARD keeps presenting the abandoned address so the cache handshake is never withdrawn.
  assign ICACHE_REQUEST = !RST && (state == FETCH || state == DISCARD);
  assign ICACHE_ADDRESS = (state == DISCARD) ? stale_addr_reg : pc_reg;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_reg;
    stale_nxt  = stale_addr_reg;
    ins_nxt    = INSTRUCTION;
    pc_out_nxt = PC_OUT;
    vld_nxt    = PC_VALID;
    skid_load  = LOW;
    skid_inv   = LOW;
    fetched    = LOW;
    if (BRANCH_TAKEN) begin
      pc_nxt     = align_word(BRANCH_TARGET);
      ins_nxt    = ZERO_WORD;
      pc_out_nxt = ZERO_WORD;
      vld_nxt    = LOW;
      skid_inv   = HIGH;
      case (state)
        FETCH: if (!ICACHE_READY) begin
          state_nxt = DISCARD;
          stale_nxt = pc_reg;
        end
        HOLD:    state_nxt = FETCH;
        default: state_nxt = state;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (ICACHE_READY) begin
            pc_nxt = pc_reg + PC_INCREMENT;
            if (STALL_FETCH_STAGE) begin
              skid_load = HIGH;
              state_nxt = HOLD;
            end else begin
              ins_nxt    = ICACHE_INSTRUCTION;
              pc_out_nxt = pc_reg;
              vld_nxt    = HIGH;
              fetched    = HIGH;
            end
          end else if (!STALL_FETCH_STAGE) begin
            ins_nxt    = ZERO_WORD;
            pc_out_nxt = ZERO_WORD;
            vld_nxt    = LOW;
          end
        end
        HOLD: if (!STALL_FETCH_STAGE) begin
          ins_nxt    = skid_ins;
          pc_out_nxt = skid_pc;
          vld_nxt    = skid_vld;
          fetched    = skid_vld;
          skid_inv   = HIGH;
          state_nxt  = FETCH;
        end
        DISCARD: begin
          if (ICACHE_READY) state_nxt = FETCH;
          if (!STALL_FETCH_STAGE) begin
            ins_nxt    = ZERO_WORD;
            pc_out_nxt = ZERO_WORD;
            vld_nxt    = LOW;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= FETCH;
      pc_reg         <= RESET_VECTOR;
      stale_addr_reg <= ZERO_WORD;
      INSTRUCTION    <= ZERO_WORD;
      PC_OUT         <= ZERO_WORD;
      PC_VALID       <= LOW;
    end else begin
      state          <= state_nxt;
      pc_reg         <= pc_nxt;
      stale_addr_reg <= stale_nxt;
      INSTRUCTION    <= ins_nxt;
      PC_OUT         <= pc_out_nxt;
      PC_VALID       <= vld_nxt;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      PERF_FETCHED     <= ZERO_WORD;
      PERF_MISS_CYCLES <= ZERO_WORD;
    end else begin
      if (fetched) PERF_FETCHED <= PERF_FETCHED + 32'd1;
      if (ICACHE_REQUEST && !ICACHE_READY) PERF_MISS_CYCLES <= PERF_MISS_CYCLES + 32'd1;
    end
  end
`else
  logic unused_fetched;
  assign unused_fetched = fetched;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed table-driven bench for instruction_fetch_stage; one row per clock cycle.
module tb_instruction_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST, STALL_FETCH_STAGE, BRANCH_TAKEN, ICACHE_READY;
  logic [31:0] BRANCH_TARGET, ICACHE_INSTRUCTION;
  logic        ICACHE_REQUEST, PC_VALID;
  logic [31:0] ICACHE_ADDRESS, INSTRUCTION, PC_OUT;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] PERF_FETCHED, PERF_MISS_CYCLES;
`endif

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  instruction_fetch_stage dut (
    .CLK                (CLK),
    .RST                (RST),
    .STALL_FETCH_STAGE  (STALL_FETCH_STAGE),
    .BRANCH_TAKEN       (BRANCH_TAKEN),
    .BRANCH_TARGET      (BRANCH_TARGET),
    .ICACHE_REQUEST     (ICACHE_REQUEST),
    .ICACHE_ADDRESS     (ICACHE_ADDRESS),
    .ICACHE_READY       (ICACHE_READY),
    .ICACHE_INSTRUCTION (ICACHE_INSTRUCTION),
    .INSTRUCTION        (INSTRUCTION),
    .PC_OUT             (PC_OUT),
`ifdef FETCH_PERF_COUNTERS_EN
    .PERF_FETCHED       (PERF_FETCHED),
    .PERF_MISS_CYCLES   (PERF_MISS_CYCLES),
`endif
    .PC_VALID           (PC_VALID)
  );

  // Inputs for one cycle, plus the outputs expected just before that cycle's edge.
  typedef struct {
    logic        rst, stall, br;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] idat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc, e_ins;
  } vec_t;

  vec_t vecs[27];

  task automatic apply(input vec_t v, input string name);
    @(negedge CLK);
    RST = v.rst; STALL_FETCH_STAGE = v.stall; BRANCH_TAKEN = v.br;
    BRANCH_TARGET = v.tgt; ICACHE_READY = v.rdy; ICACHE_INSTRUCTION = v.idat;
    #2;
    tests++;
    if (ICACHE_REQUEST !== v.e_req || (v.e_req && ICACHE_ADDRESS !== v.e_addr) ||
        PC_VALID !== v.e_vld || PC_OUT !== v.e_pc || INSTRUCTION !== v.e_ins) begin
      fails++;
      $display("FAIL %s: got req=%0b addr=%h vld=%0b pc=%h ins=%h, want req=%0b addr=%h vld=%0b pc=%h ins=%h",
               name, ICACHE_REQUEST, ICACHE_ADDRESS, PC_VALID, PC_OUT, INSTRUCTION,
               v.e_req, v.e_addr, v.e_vld, v.e_pc, v.e_ins);
    end
  endtask

  initial begin
    //           rst  stl  br   tgt           rdy  idat           req  addr          vld  pc            ins
    vecs[0]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,        32'h0};
    vecs[1]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h11,        1'b1,32'h0,        1'b0,32'h0,        32'h0};
    vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h22,        1'b1,32'h4,        1'b1,32'h0,        32'h11};
    vecs[3]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h33,        1'b1,32'h8,        1'b1,32'h4,        32'h22};
    vecs[4]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h44,        1'b1,32'hC,        1'b1,32'h8,        32'h33};
    vecs[5]  = '{1'b0,1'b0,1'b1,32'h40,       1'b1,32'h55,        1'b1,32'h10,       1'b1,32'hC,        32'h44};
    vecs[6]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h40,       1'b0,32'h0,        32'h0};
    vecs[7]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h40,       1'b0,32'h0,        32'h0};
    vecs[8]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h40,       1'b0,32'h0,        32'h0};
    vecs[9]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h66,        1'b1,32'h40,       1'b0,32'h0,        32'h0};
    vecs[10] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h00500093,  1'b1,32'h44,       1'b1,32'h40,       32'h66};
    vecs[11] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,         1'b0,32'h0,        1'b1,32'h40,       32'h66};
    vecs[12] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hDEAD,      1'b0,32'h0,        1'b1,32'h40,       32'h66};
    vecs[13] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b0,32'h0,        1'b1,32'h40,       32'h66};
    vecs[14] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h48,       1'b1,32'h44,       32'h00500093};
    vecs[15] = '{1'b0,1'b0,1'b1,32'h103,      1'b0,32'h0,         1'b1,32'h48,       1'b0,32'h0,        32'h0};
    vecs[16] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h48,       1'b0,32'h0,        32'h0};
    vecs[17] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hBAD,       1'b1,32'h48,       1'b0,32'h0,        32'h0};
    vecs[18] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h77,        1'b1,32'h100,      1'b0,32'h0,        32'h0};
    vecs[19] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h88,        1'b1,32'h104,      1'b1,32'h100,      32'h77};
    vecs[20] = '{1'b0,1'b1,1'b1,32'h200,      1'b0,32'h0,         1'b0,32'h0,        1'b1,32'h100,      32'h77};
    vecs[21] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h99,        1'b1,32'h200,      1'b0,32'h0,        32'h0};
    vecs[22] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h204,      1'b1,32'h200,      32'h99};
    vecs[23] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,        32'h0};
    vecs[24] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'hBAD,       1'b0,32'h0,        1'b0,32'h0,        32'h0};
    vecs[25] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hAA,        1'b1,32'h0,        1'b0,32'h0,        32'h0};
    vecs[26] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h4,        1'b1,32'h0,        32'hAA};

    RST = 1'b1; STALL_FETCH_STAGE = 1'b0; BRANCH_TAKEN = 1'b0;
    BRANCH_TARGET = 32'h0; ICACHE_READY = 1'b0; ICACHE_INSTRUCTION = 32'h0;
    repeat (2) @(posedge CLK);

    for (int i = 0; i < 27; i++) apply(vecs[i], $sformatf("row%0d", i));

    // Redirects while discarding only move the target; then fetch wraps past 0xFFFF_FFFC.
    apply('{1'b0,1'b0,1'b1,32'hFFFF_FFFF,1'b0,32'h0,  1'b1,32'h4,         1'b0,32'h0,         32'h0},  "disc_enter");
    apply('{1'b0,1'b0,1'b1,32'h300,      1'b0,32'h0,  1'b1,32'h4,         1'b0,32'h0,         32'h0},  "disc_rebranch1");
    apply('{1'b0,1'b0,1'b1,32'hFFFF_FFFE,1'b0,32'h0,  1'b1,32'h4,         1'b0,32'h0,         32'h0},  "disc_rebranch2");
    apply('{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h12, 1'b1,32'h4,         1'b0,32'h0,         32'h0},  "disc_drop");
    apply('{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hC1, 1'b1,32'hFFFF_FFFC, 1'b0,32'h0,         32'h0},  "wrap_req");
    apply('{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hC2, 1'b1,32'h0,         1'b1,32'hFFFF_FFFC, 32'hC1}, "wrap_next");
    apply('{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b1,32'h4,         1'b1,32'h0,         32'hC2}, "wrap_out");
    // Stall in FETCH with no response holds the outputs and keeps the request up.
    apply('{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,  1'b1,32'h4,         1'b0,32'h0,         32'h0},  "stall_miss");
    apply('{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hE4, 1'b1,32'h4,         1'b0,32'h0,         32'h0},  "stall_miss_rel");
    apply('{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b1,32'h8,         1'b1,32'h4,         32'hE4}, "after_miss");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Front-end pipeline stage that produces the `INSTRUCTION`, `PC_IN` and `PC_VALID` stream consumed by the decoding stage. It drives requests to the instruction cache and tracks the next-fetch PC. It honours the same stall signal as the decode stage and buffers one returned instruction while stalled. Branch redirects from execute flush its output register and discard any in-flight cache response.

## Interface
Parameters:
- `RESET_VECTOR`, default `32'h0000_0000`: first fetch address after reset.
- `HIGH`, default `1'b1`: logic-high constant.
- `LOW`, default `1'b0`: logic-low constant.

Ports:
- `CLK`  in  1  clock. One clock domain only.
- `RST`  in  1  reset. Synchronous, active-high.
- `STALL_FETCH_STAGE`  in  1  hazard-unit stall. Tied to the same source as the decode-stage stall.
- `BRANCH_TAKEN`  in  1  redirect request from execute.
- `BRANCH_TARGET`  in  32  redirect address. Bits [1:0] are ignored and treated as 0.
- `ICACHE_REQUEST`  out  1  fetch request to the instruction cache.
- `ICACHE_ADDRESS`  out  32  fetch address. Word-aligned.
- `ICACHE_READY`  in  1  response strobe. `ICACHE_INSTRUCTION` is valid in the same cycle.
- `ICACHE_INSTRUCTION`  in  32  returned instruction word.
- `INSTRUCTION`  out  32  registered instruction to decode.
- `PC_OUT`  out  32  registered PC of `INSTRUCTION`. Connects to the decode `PC_IN`.
- `PC_VALID`  out  1  `INSTRUCTION` and `PC_OUT` are valid.

## Operation
- Registers:
  - `pc_reg`: next fetch address.
  - `stale_addr_reg`: address of the abandoned request.
  - Skid buffer: one entry holding an instruction and its PC.
  - Output registers: `INSTRUCTION`, `PC_OUT`, `PC_VALID`.
  - `state`.
- Cache handshake:
  - Once `ICACHE_REQUEST` is high, both `ICACHE_REQUEST` and `ICACHE_ADDRESS` stay stable until the cycle in which `ICACHE_READY` is high. A request is never withdrawn.
  - `ICACHE_READY` may arrive in the same cycle as the request (hit) or any number of cycles later (miss).
  - `ICACHE_READY` is ignored while `ICACHE_REQUEST` is low.
- States:
  - **FETCH**: `ICACHE_REQUEST`=1, `ICACHE_ADDRESS`=`pc_reg`. When `ICACHE_READY` arrives, `pc_reg` advances by 4.
    - Not stalled: output registers load the returned instruction with `PC_VALID`=1.
    - Stalled: the skid buffer captures the returned instruction, output registers hold, and the state moves to HOLD.
    - No `ICACHE_READY` and not stalled: `PC_VALID`<=0 and `INSTRUCTION`/`PC_OUT`<=0 (a bubble).
  - **HOLD**: `ICACHE_REQUEST`=0. When the stall drops, output registers load from the skid buffer with `PC_VALID`=1, and the state moves to FETCH.
  - **DISCARD**: `ICACHE_REQUEST`=1, `ICACHE_ADDRESS`=`stale_addr_reg`. When `ICACHE_READY` arrives, the response is dropped and the state moves to FETCH.
- Stall: while asserted, the output registers hold their value.
- `BRANCH_TAKEN` has priority over stall and over a same-cycle `ICACHE_READY`. Actions:
  - `pc_reg`<={`BRANCH_TARGET`[31:2],2'b00}.
  - Output registers cleared: `PC_VALID`=0, `INSTRUCTION`=0, `PC_OUT`=0.
  - Skid buffer invalidated.
  - Next state:
    - From FETCH with `ICACHE_READY` low: move to DISCARD and set `stale_addr_reg`<=`pc_reg`.
    - From FETCH with `ICACHE_READY` high: stay in FETCH and drop the response.
    - From HOLD: move to FETCH.
    - From DISCARD: stay in DISCARD. Only `pc_reg` changes.
- PC arithmetic: modulo 2^32. `32'hFFFF_FFFC`+4 wraps to 0.
- Reset (`RST`=1 at a clock edge):
  - `pc_reg`<=`RESET_VECTOR`, state<=FETCH, skid buffer invalid.
  - `PC_VALID`=0, `INSTRUCTION`=0, `PC_OUT`=0.
  - `ICACHE_REQUEST` is forced to 0 combinationally while `RST` is high.
  - Reset mid-DISCARD or mid-miss abandons the response. The cache is reset by the same `RST`.

## Timing
- `ICACHE_READY` (not stalled) to `PC_VALID`=1: 1 cycle.
- Back-to-back hits: one instruction per cycle.
- `BRANCH_TAKEN` in cycle N: the target request is issued in cycle N+1. With a hit, the target instruction appears at the outputs in cycle N+2.
- Stall release in HOLD: the buffered instruction appears at the outputs on the next edge. The next request is issued in the cycle after that.
- First request after reset: the first cycle with `RST` low.

## Configuration
- `FETCH_PERF_COUNTERS_EN` defined:
  - Adds output `PERF_FETCHED`, 32 bits: count of instructions loaded into the output registers with `PC_VALID`=1.
  - Adds output `PERF_MISS_CYCLES`, 32 bits: count of cycles with `ICACHE_REQUEST`=1 and `ICACHE_READY`=0.
  - Both counters reset to 0 and wrap.
- `FETCH_PERF_COUNTERS_EN` undefined: both ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- Package `riscv_fetch_pkg` holds:
  - State encoding: FETCH=2'd0, HOLD=2'd1, DISCARD=2'd2.
  - `PC_INCREMENT`=32'd4.
  - Default `RESET_VECTOR`.
  - `ZERO_WORD` constant.
- Sub-module `fetch_skid_buffer`: one-entry buffer with load, invalidate and valid flag, holding the instruction and its PC.

## Test plan
- Hits every cycle from reset with `RESET_VECTOR`=0 -> `PC_OUT` sequence 0, 4, 8, 12 on consecutive cycles, starting 1 cycle after the first `ICACHE_READY`.
- Miss with 3-cycle `ICACHE_READY` delay at `32'h40` -> `ICACHE_ADDRESS` stable at `32'h40` for 4 cycles. `PC_VALID`=0 for those cycles, then `PC_OUT`=`32'h40`.
- Stall asserted when `ICACHE_READY` returns word `32'h00500093` -> outputs hold for the whole stall and `ICACHE_REQUEST`=0. One cycle after release, `INSTRUCTION`=`32'h00500093`.
- `BRANCH_TAKEN` to `32'h103` during a pending miss -> `ICACHE_ADDRESS` stays at the old PC until `ICACHE_READY`, and that response is never output. Next request is to `32'h100`, and the next valid `PC_OUT`=`32'h100`.
- `BRANCH_TAKEN` together with stall in HOLD -> `PC_VALID`=0 on the next cycle, the buffer is dropped, and fetch resumes at the target.
- `RST` pulsed mid-miss -> all outputs 0 and `ICACHE_REQUEST`=0 during reset. The next request goes to `RESET_VECTOR`.
